// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, runs req/ack reads to instruction memory, hands words to the IR.
// Latency: min 2 cycles per instruction (launch cycle + ack cycle); all outputs registered.
// Backpressure: i_stall blocks new launches only; an in-flight fetch always runs to ack, flush or timeout.
//
// Ports:
//   i_clk, i_rst (async, active-low)            clock and reset
//   i_stall                                     suppress launching a new fetch
//   i_branch_taken / i_branch_target            one-cycle redirect request and its target
//   o_mem_req / o_mem_addr                      read request; address held stable while requesting
//   i_mem_ack / i_mem_rdata                     read completion and returned word
//   o_ir_data / o_ir_en                         fetched word and one-cycle load enable for the IR
//   o_pc                                        current program counter
//   o_fault                                     sticky memory-timeout flag
module instr_fetch #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [15:0] PC_STEP      = 16'h0001,
    parameter logic [7:0]  MAX_WAIT     = 8'd255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [15:0] i_branch_target,
    output logic        o_mem_req,
    output logic [15:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [15:0] i_mem_rdata,
    output logic [15:0] o_ir_data,
    output logic        o_ir_en,
    output logic [15:0] o_pc,
    output logic        o_fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    // Last FETCH cycle index that may still be waited out; the request is
    // therefore held for exactly MAX_WAIT cycles before giving up.
    localparam logic [7:0] WAIT_LAST = MAX_WAIT - 8'd1;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_mem_addr;
    logic        r_mem_req;
    logic [15:0] r_ir_data;
    logic        r_ir_en;
    logic        r_fault;
    logic [7:0]  r_wait_cnt;
    logic        r_flush_pending;
    logic [15:0] r_flush_target;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state         <= S_IDLE;
            r_pc            <= RESET_VECTOR;
            r_mem_addr      <= RESET_VECTOR;
            r_mem_req       <= 1'b0;
            r_ir_data       <= 16'h0000;
            r_ir_en         <= 1'b0;
            r_fault         <= 1'b0;
            r_wait_cnt      <= 8'd0;
            r_flush_pending <= 1'b0;
            r_flush_target  <= 16'h0000;
        end else begin
            // Load enable is a single-cycle pulse; only a clean delivery raises it.
            r_ir_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_branch_taken) begin
                        r_pc <= i_branch_target;
                    end else if (!i_stall) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_pc;
                        r_wait_cnt <= 8'd0;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (i_mem_ack) begin
                        // A same-cycle redirect beats a recorded one; either way the
                        // returned word belongs to the wrong path and is dropped.
                        if (i_branch_taken) begin
                            r_pc <= i_branch_target;
                        end else if (r_flush_pending) begin
                            r_pc <= r_flush_target;
                        end else begin
                            r_ir_data <= i_mem_rdata;
                            r_ir_en   <= 1'b1;
                            r_pc      <= r_pc + PC_STEP;
                        end
                        r_flush_pending <= 1'b0;
                        r_mem_req       <= 1'b0;
                        r_state         <= S_IDLE;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_mem_req <= 1'b0;
                        r_fault   <= 1'b1;
                        r_state   <= S_FAULT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                        // Request stays up; the redirect is applied when the ack arrives.
                        if (i_branch_taken) begin
                            r_flush_target  <= i_branch_target;
                            r_flush_pending <= 1'b1;
                        end
                    end
                end
                S_FAULT: begin
                    // Terminal: only reset leaves this state.
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mem_req  = r_mem_req;
    assign o_mem_addr = r_mem_addr;
    assign o_ir_data  = r_ir_data;
    assign o_ir_en    = r_ir_en;
    assign o_pc       = r_pc;
    assign o_fault    = r_fault;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit of the 16-bit CPU.
- Holds the program counter and runs a req/ack read transaction to instruction memory.
- Delivers each fetched word, with a one-cycle load enable, to the downstream 16-bit instruction register.
- Handles branch redirects, including one that arrives mid-fetch, and raises a sticky fault if memory never acknowledges.

Parameters:
- RESET_VECTOR, 16'h0000, PC value loaded at reset.
- PC_STEP, 16'h0001, PC increment per delivered instruction (word-addressed memory).
- MAX_WAIT, 8'd255, cycles in FETCH without ack before FAULT; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- stall  input  1  when 1, no new fetch is launched.
- branch_taken  input  1  one-cycle redirect request.
- branch_target  input  16  redirect address, valid with branch_taken.
- mem_req  output  1  read request to instruction memory.
- mem_addr  output  16  read address; stable while mem_req=1.
- mem_ack  input  1  memory has placed valid data on mem_rdata this cycle.
- mem_rdata  input  16  instruction word.
- ir_data  output  16  fetched instruction to the downstream register.
- ir_en  output  1  one-cycle load enable for the downstream register.
- pc  output  16  current program counter.
- fault  output  1  sticky memory-timeout flag.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - pc=RESET_VECTOR, mem_addr=RESET_VECTOR.
  - mem_req=0, ir_en=0, ir_data=16'h0000, fault=0.
  - wait counter=0, flush_pending=0, state=IDLE.
- Register timing:
  - All outputs are registered on the rising edge of clk.
  - ir_data/ir_en are therefore stable across the falling edge, where the downstream register samples.
- States: IDLE, FETCH, FAULT.
- IDLE:
  - branch_taken=1: pc<=branch_target, stay IDLE. Applies regardless of stall.
  - Otherwise, stall=0: mem_req<=1, mem_addr<=pc, wait counter<=0, go FETCH.
  - Otherwise, stall=1: hold everything.
- FETCH:
  - mem_req stays 1 and mem_addr stays unchanged until exit.
  - mem_ack=1, no flush pending, branch_taken=0:
    - ir_data<=mem_rdata, ir_en<=1 for exactly one cycle.
    - pc<=pc+PC_STEP, mem_req<=0, go IDLE.
  - branch_taken=1 while mem_ack=0:
    - Record target, set flush_pending.
    - The request is not withdrawn.
    - A later branch_taken before ack overwrites the recorded target.
  - mem_ack=1 with flush_pending=1, or with branch_taken=1 in the same cycle:
    - Data discarded, ir_en stays 0, ir_data unchanged.
    - pc<=target; a same-cycle branch_target has priority over the recorded target.
    - flush_pending<=0, mem_req<=0, go IDLE.
  - mem_ack=0: wait counter increments each cycle.
  - Timeout: counter==MAX_WAIT-1 with mem_ack=0 → mem_req<=0, fault<=1, go FAULT.
  - stall has no effect in FETCH; an in-flight fetch always completes.
- FAULT:
  - Terminal until rst=0.
  - mem_req=0, ir_en=0, fault=1; pc frozen.
  - All inputs ignored.
- Minimum throughput: one instruction per 2 cycles (ack in the first FETCH cycle).
- ir_en is never high on two consecutive cycles.
- Arithmetic: pc+PC_STEP is 16-bit modulo; 16'hFFFF+1 wraps to 16'h0000 with no flag.
- mem_ack outside FETCH is ignored.
- Reset mid-FETCH: mem_req drops immediately (asynchronous); the pending transaction is abandoned, and memory is required to tolerate this.

Test Plan:
1. Release reset, stall=0, memory acks every cycle it sees mem_req, returning words 16'hA000, 16'hA001, 16'hA002:
   - mem_addr=0,1,2 on successive fetches.
   - ir_en pulses every 2nd cycle with ir_data=A000, A001, A002.
   - pc ends at 3.
2. pc=16'hFFFF, ack with 16'h1234:
   - ir_data=1234, pc wraps to 16'h0000, next mem_addr=0.
3. Mid-FETCH redirect: branch_taken with target 16'h0040 in FETCH (addr 5), ack 3 cycles later:
   - No ir_en pulse.
   - pc=16'h0040; next request at 16'h0040.
   - Repeat with branch_taken and mem_ack in the same cycle → same result.
4. Stall: stall=1 in IDLE for 4 cycles → mem_req stays 0. Then:
   - branch_taken with 16'h0100 during the stall → pc=16'h0100.
   - Release stall → fetch at 16'h0100.
   - stall raised during FETCH → that fetch still delivers.
5. Timeout: MAX_WAIT=4, never ack:
   - mem_req high exactly 4 cycles, then fault=1, mem_req=0.
   - Later acks and branches are ignored; pc is unchanged until rst=0.
6. Asynchronous reset: assert rst=0 mid-FETCH between clock edges:
   - mem_req, ir_en, fault go 0 and pc=RESET_VECTOR without a clock edge.
   - After release, fetch restarts at RESET_VECTOR.
